// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth signed multiplier with a start/busy/done handshake.
// Optional macro BOOTH_EARLY_ZERO_EN completes at once when either operand is zero.
`timescale 1ns/1ps

module booth_mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             overflow
);

    // state | meaning
    // IDLE  | waiting for start; operands latched on the start edge
    // RUN   | one Booth step per clock, WIDTH steps total
    // DONE  | one-cycle done pulse, hi/lo/overflow valid

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nxt;

    // The accumulator carries one guard bit so that subtracting the most-negative
    // multiplicand cannot flip the sign of the partial product.
    logic [WIDTH:0]   m_reg;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic             q_m1;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   acc_sum;
    logic [WIDTH:0]   acc_shift;
    logic [WIDTH-1:0] q_shift;
    logic             last_step;
    logic             zero_op;

`ifdef BOOTH_EARLY_ZERO_EN
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_comb begin
        acc_sum = acc;
        case ({q[0], q_m1})
            2'b01:   acc_sum = acc + m_reg;
            2'b10:   acc_sum = acc - m_reg;
            default: acc_sum = acc;
        endcase
    end

    assign acc_shift = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
    assign q_shift   = {acc_sum[0], q[WIDTH-1:1]};
    assign last_step = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = zero_op ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_reg    <= '0;
            acc      <= '0;
            q        <= '0;
            q_m1     <= 1'b0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m_reg <= {a[WIDTH-1], a};
                        acc   <= '0;
                        q     <= b;
                        q_m1  <= 1'b0;
                        cnt   <= '0;
                        if (zero_op) begin
                            hi       <= '0;
                            lo       <= '0;
                            overflow <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    acc  <= acc_shift;
                    q    <= q_shift;
                    q_m1 <= q[0];
                    cnt  <= cnt + CW'(1);
                    if (last_step) begin
                        hi       <= acc_shift[WIDTH-1:0];
                        lo       <= q_shift;
                        overflow <= (acc_shift[WIDTH-1:0] != {WIDTH{q_shift[WIDTH-1]}});
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed testbench for booth_mult_seq: hand-computed products, latency,
// handshake, mid-run reset, ignored starts and the zero-operand path.
`timescale 1ns/1ps

module tb_booth_mult_seq;

    localparam int W = 32;
`ifdef BOOTH_EARLY_ZERO_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, overflow;
    logic [W-1:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after the start edge until done is seen.
    task automatic wait_done(input string tag, output int lat, output bit busy_seen);
        lat       = 0;
        busy_seen = busy;
        while (!done && lat < 100) begin
            tick();
            lat++;
            if (busy) busy_seen = 1'b1;
        end
        check_val({tag, "_done_seen"}, done, 1);
        check_val({tag, "_excl"}, busy & done, 0);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                          input logic exp_ov, input int exp_lat, input bit exp_busy);
        int lat;
        bit bs;
        a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~av; b = ~bv;
        wait_done(tag, lat, bs);
        check_val({tag, "_lat"}, lat, exp_lat);
        check_val({tag, "_busy_seen"}, bs, exp_busy);
        check_val({tag, "_hi"}, hi, exp_hi);
        check_val({tag, "_lo"}, lo, exp_lo);
        check_val({tag, "_ov"}, overflow, exp_ov);
        tick();
        check_val({tag, "_done_width"}, done, 0);
        check_val({tag, "_hold_lo"}, lo, exp_lo);
    endtask

    initial begin
        int lat;
        int done_cnt;
        bit bs;

        reset = 1'b0; start = 1'b0; a = '0; b = '0;
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_hilo", {hi, lo}, 0);
        check_val("rst_ov", overflow, 0);
        tick(); tick();
        reset = 1'b1;
        tick();

        run_op("m7xm3", 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, W, 1'b1);

        // Reset dropped mid-run, away from a clock edge.
        a = 32'd5; b = 32'd6; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        #2;
        reset = 1'b0;
        #1;
        check_val("midrst_busy", busy, 0);
        check_val("midrst_done", done, 0);
        check_val("midrst_hi", hi, 0);
        check_val("midrst_lo", lo, 0);
        check_val("midrst_ov", overflow, 0);
        tick();
        reset = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) done_cnt++;
        end
        check_val("midrst_no_done", done_cnt, 0);
        check_val("midrst_idle", busy, 0);

        run_op("minxmin", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b1, W, 1'b1);
        run_op("maxx2", 32'h7FFF_FFFF, 32'd2, 32'h0, 32'hFFFF_FFFE, 1'b1, W, 1'b1);
        run_op("m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0, W, 1'b1);

        // Starts during RUN and in the DONE cycle must be ignored.
        a = 32'd3; b = 32'd4; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        a = 32'd9; b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ign", lat, bs);
        check_val("ign_lat", lat + 5, W);
        check_val("ign_hi", hi, 0);
        check_val("ign_lo", lo, 12);
        a = 32'd9; b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        check_val("ign_done_width", done, 0);
        check_val("ign_no_restart", busy, 0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy) done_cnt++;
        end
        check_val("ign_single_done", done_cnt, 0);
        check_val("ign_hold_lo", lo, 12);

        run_op("fresh9x9", 32'd9, 32'd9, 32'h0, 32'd81, 1'b0, W, 1'b1);
        run_op("zero", 32'd0, 32'd5, 32'h0, 32'h0, 1'b0, EARLY ? 0 : W, !EARLY);
        run_op("m123xm5", 32'd123, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FD99, 1'b0, W, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
